// File: rtl/inst_rom_pkg.sv
// Shared types and constants for the instruction ROM and its byte-serial loader.
package inst_rom_pkg;

  localparam int InstMemNumLog2 = 10;

  typedef logic [31:0] inst_bus_t;
  typedef logic [31:0] inst_addr_t;

  localparam logic      ChipEnable  = 1'b1;
  localparam logic      ChipDisable = 1'b0;
  localparam inst_bus_t ZeroWord    = 32'h0000_0000;

  typedef enum logic [1:0] {
    LdIdle = 2'd0,
    LdLoad = 2'd1,
    LdDone = 2'd2
  } ld_state_e;

  // Big-endian packing: byte index 0 lands in the most significant lane.
  function automatic inst_bus_t put_byte(input inst_bus_t word, input logic [1:0] idx,
                                         input logic [7:0] data);
    inst_bus_t w;
    w = word;
    case (idx)
      2'd0:    w[31:24] = data;
      2'd1:    w[23:16] = data;
      2'd2:    w[15:8]  = data;
      default: w[7:0]   = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/inst_rom_if.sv
// Fetch and program-load bus between the core/loader source (master) and the ROM (slave).
interface inst_rom_if
  import inst_rom_pkg::*;
#(
  parameter int DEPTH_LOG2 = InstMemNumLog2
) ();

  logic                ce;
  inst_addr_t          addr;
  inst_bus_t           inst;
  logic                ld_start;
  logic                ld_valid;
  logic [7:0]          ld_byte;
  logic                ld_ready;
  logic                ld_end;
  logic                ld_done;
  logic                ld_overflow;
  logic [DEPTH_LOG2:0] ld_words;
  logic                cpu_hold;

  modport master (
    output ce, addr, ld_start, ld_valid, ld_byte, ld_end,
    input  inst, ld_ready, ld_done, ld_overflow, ld_words, cpu_hold
  );

  modport slave (
    input  ce, addr, ld_start, ld_valid, ld_byte, ld_end,
    output inst, ld_ready, ld_done, ld_overflow, ld_words, cpu_hold
  );

endinterface

// File: rtl/inst_rom_loader.sv
// Byte-serial program loader: packs bytes big-endian into words and streams them into the ROM array.
module inst_rom_loader
  import inst_rom_pkg::*;
#(
  parameter int DEPTH_LOG2 = InstMemNumLog2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_valid,
  input  logic [7:0]            i_byte,
  input  logic                  i_end,
  output logic                  o_ready,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [DEPTH_LOG2:0]   o_words,
  output logic                  o_hold,
  output logic                  o_we,
  output logic [DEPTH_LOG2-1:0] o_waddr,
  output inst_bus_t             o_wdata
);

  ld_state_e           r_state;
  logic [DEPTH_LOG2:0] r_wptr;
  logic [1:0]          r_bcnt;
  inst_bus_t           r_word;
  logic                r_ready;
  logic                r_done;
  logic                r_overflow;
  logic                r_hold;

  logic      w_load;
  logic      w_accept;
  logic      w_full;
  logic      w_last;
  logic      w_flush;
  inst_bus_t w_word;

  // A restart pulse in LOAD takes priority over any byte or end marker in the same cycle.
  assign w_load   = (r_state == LdLoad);
  assign w_accept = w_load && !i_start && i_valid;
  assign w_full   = r_wptr[DEPTH_LOG2];
  assign w_word   = w_accept ? put_byte(r_word, r_bcnt, i_byte) : r_word;
  assign w_last   = w_accept && (r_bcnt == 2'd3);
  assign w_flush  = w_load && !i_start && i_end && ((r_bcnt != 2'd0) || w_accept);

  assign o_we       = rst && !w_full && (w_last || w_flush);
  assign o_waddr    = r_wptr[DEPTH_LOG2-1:0];
  assign o_wdata    = w_word;
  assign o_ready    = r_ready;
  assign o_done     = r_done;
  assign o_overflow = r_overflow;
  assign o_words    = r_wptr;
  assign o_hold     = r_hold;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= LdIdle;
      r_wptr     <= '0;
      r_bcnt     <= 2'd0;
      r_word     <= ZeroWord;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_hold     <= 1'b0;
    end else begin
      case (r_state)
        LdIdle, LdDone: begin
          if (i_start) begin
            r_state    <= LdLoad;
            r_wptr     <= '0;
            r_bcnt     <= 2'd0;
            r_word     <= ZeroWord;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
            r_hold     <= 1'b1;
          end
        end
        LdLoad: begin
          if (i_start) begin
            r_wptr     <= '0;
            r_bcnt     <= 2'd0;
            r_word     <= ZeroWord;
            r_overflow <= 1'b0;
          end else begin
            if (w_accept) begin
              if (w_full) begin
                r_overflow <= 1'b1;
              end else if (w_last) begin
                r_bcnt <= 2'd0;
                r_word <= ZeroWord;
              end else begin
                r_bcnt <= r_bcnt + 2'd1;
                r_word <= w_word;
              end
            end
            if (o_we) r_wptr <= r_wptr + 1'b1;
            // Ending flushes any partial word (written above) and leaves the packer empty.
            if (i_end) begin
              r_state <= LdDone;
              r_done  <= 1'b1;
              r_ready <= 1'b0;
              r_hold  <= 1'b0;
              r_bcnt  <= 2'd0;
              r_word  <= ZeroWord;
            end
          end
        end
        default: r_state <= LdIdle;
      endcase
    end
  end

endmodule

// File: rtl/inst_rom.sv
// Instruction memory: zero-latency fetch port for the core plus an embedded program loader.
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int DEPTH_LOG2 = InstMemNumLog2
) (
  input logic       clk,
  input logic       rst,
  inst_rom_if.slave bus
);

  inst_bus_t r_mem [2**DEPTH_LOG2];

  logic                  w_we;
  logic [DEPTH_LOG2-1:0] w_waddr;
  inst_bus_t             w_wdata;
  logic                  w_in_range;
  logic                  w_unused;

  inst_rom_loader #(.DEPTH_LOG2(DEPTH_LOG2)) u_loader (
    .clk        (clk),
    .rst        (rst),
    .i_start    (bus.ld_start),
    .i_valid    (bus.ld_valid),
    .i_byte     (bus.ld_byte),
    .i_end      (bus.ld_end),
    .o_ready    (bus.ld_ready),
    .o_done     (bus.ld_done),
    .o_overflow (bus.ld_overflow),
    .o_words    (bus.ld_words),
    .o_hold     (bus.cpu_hold),
    .o_we       (w_we),
    .o_waddr    (w_waddr),
    .o_wdata    (w_wdata)
  );

  // The array is deliberately not reset so a program survives a core reset.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign w_in_range = (bus.addr[31:DEPTH_LOG2+2] == '0);
  assign w_unused   = &{1'b0, bus.addr[1:0]};

  // Fetches beyond the array read as a NOP rather than aliasing into it.
  always_comb begin
    bus.inst = ZeroWord;
    if ((bus.ce == ChipEnable) && w_in_range) bus.inst = r_mem[bus.addr[DEPTH_LOG2+1:2]];
  end

endmodule

// File: tb/tb_inst_rom.sv
// Directed self-checking bench for inst_rom: a full-size instance and a 4-word instance for overflow.
module tb_inst_rom;
  import inst_rom_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  inst_rom_if #(.DEPTH_LOG2(10)) bus10 ();
  inst_rom_if #(.DEPTH_LOG2(2))  bus2 ();

  inst_rom #(.DEPTH_LOG2(10)) dut   (.clk(clk), .rst(rst), .bus(bus10));
  inst_rom #(.DEPTH_LOG2(2))  dut_s (.clk(clk), .rst(rst), .bus(bus2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send10(input logic [7:0] b);
    bus10.ld_valid = 1'b1;
    bus10.ld_byte  = b;
    tick();
    bus10.ld_valid = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b);
    bus2.ld_valid = 1'b1;
    bus2.ld_byte  = b;
    tick();
    bus2.ld_valid = 1'b0;
  endtask

  task automatic start10;
    bus10.ld_start = 1'b1;
    tick();
    bus10.ld_start = 1'b0;
  endtask

  task automatic end10;
    bus10.ld_end = 1'b1;
    tick();
    bus10.ld_end = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus10.ld_valid = 1'b1;
    bus2.ld_valid  = 1'b1;
    tick();
    tick();
    bus10.ld_valid = 1'b0;
    bus2.ld_valid  = 1'b0;
    checks++; if (bus10.ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b expected 0", bus10.ld_ready); end
    checks++; if (bus10.ld_words !== 11'd0) begin errors++; $display("[TB] FAIL reset_words got %0d expected 0", bus10.ld_words); end
    checks++; if (bus10.cpu_hold !== 1'b0) begin errors++; $display("[TB] FAIL reset_hold got %b expected 0", bus10.cpu_hold); end
    checks++; if (bus10.ld_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", bus10.ld_done); end
    checks++; if (bus2.ld_overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b expected 0", bus2.ld_overflow); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load;
    start10();
    checks++; if (bus10.cpu_hold !== 1'b1) begin errors++; $display("[TB] FAIL load_hold_rise got %b expected 1", bus10.cpu_hold); end
    checks++; if (bus10.ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL load_ready got %b expected 1", bus10.ld_ready); end
    send10(8'h34); send10(8'h01); send10(8'h11); send10(8'h00);
    checks++; if (bus10.ld_words !== 11'd1) begin errors++; $display("[TB] FAIL load_words_mid got %0d expected 1", bus10.ld_words); end
    send10(8'h34); send10(8'h02); send10(8'h00); send10(8'h20);
    end10();
    checks++; if (bus10.ld_words !== 11'd2) begin errors++; $display("[TB] FAIL load_words got %0d expected 2", bus10.ld_words); end
    checks++; if (bus10.ld_done !== 1'b1) begin errors++; $display("[TB] FAIL load_done got %b expected 1", bus10.ld_done); end
    checks++; if (bus10.cpu_hold !== 1'b0) begin errors++; $display("[TB] FAIL load_hold_fall got %b expected 0", bus10.cpu_hold); end
    bus10.ce = 1'b1; bus10.addr = 32'h0; #1;
    checks++; if (bus10.inst !== 32'h34011100) begin errors++; $display("[TB] FAIL load_fetch0 got %h expected 34011100", bus10.inst); end
    bus10.addr = 32'h6; #1;
    checks++; if (bus10.inst !== 32'h34020020) begin errors++; $display("[TB] FAIL load_fetch6 got %h expected 34020020", bus10.inst); end
  endtask

  task automatic test_partial;
    start10();
    send10(8'hAA);
    bus10.ld_valid = 1'b1; bus10.ld_byte = 8'hBB; bus10.ld_end = 1'b1;
    bus10.ce = 1'b1; bus10.addr = 32'h0; #1;
    checks++; if (bus10.inst !== 32'h34011100) begin errors++; $display("[TB] FAIL partial_old_word got %h expected 34011100", bus10.inst); end
    tick();
    bus10.ld_valid = 1'b0; bus10.ld_end = 1'b0; #1;
    checks++; if (bus10.inst !== 32'hAABB0000) begin errors++; $display("[TB] FAIL partial_word got %h expected aabb0000", bus10.inst); end
    checks++; if (bus10.ld_words !== 11'd1) begin errors++; $display("[TB] FAIL partial_words got %0d expected 1", bus10.ld_words); end
    bus10.addr = 32'h4; #1;
    checks++; if (bus10.inst !== 32'h34020020) begin errors++; $display("[TB] FAIL partial_next_kept got %h expected 34020020", bus10.inst); end
  endtask

  task automatic test_fetch_guards;
    bus10.ce = 1'b0; bus10.addr = 32'h0; #1;
    checks++; if (bus10.inst !== 32'h0) begin errors++; $display("[TB] FAIL guard_ce got %h expected 0", bus10.inst); end
    bus10.ce = 1'b1; bus10.addr = 32'h0000_1000; #1;
    checks++; if (bus10.inst !== 32'h0) begin errors++; $display("[TB] FAIL guard_range got %h expected 0", bus10.inst); end
    bus10.addr = 32'h8000_0000; #1;
    checks++; if (bus10.inst !== 32'h0) begin errors++; $display("[TB] FAIL guard_high got %h expected 0", bus10.inst); end
    bus10.addr = 32'h3; #1;
    checks++; if (bus10.inst !== 32'hAABB0000) begin errors++; $display("[TB] FAIL guard_lowbits got %h expected aabb0000", bus10.inst); end
  endtask

  task automatic test_overflow;
    bus2.ld_start = 1'b1; tick(); bus2.ld_start = 1'b0;
    for (int i = 1; i <= 16; i++) send2(8'(i));
    checks++; if (bus2.ld_words !== 3'd4) begin errors++; $display("[TB] FAIL ovf_words_full got %0d expected 4", bus2.ld_words); end
    checks++; if (bus2.ld_overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_not_yet got %b expected 0", bus2.ld_overflow); end
    for (int i = 17; i <= 20; i++) send2(8'(i));
    checks++; if (bus2.ld_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b expected 1", bus2.ld_overflow); end
    checks++; if (bus2.ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL ovf_ready got %b expected 1", bus2.ld_ready); end
    checks++; if (bus2.ld_words !== 3'd4) begin errors++; $display("[TB] FAIL ovf_words got %0d expected 4", bus2.ld_words); end
    bus2.ld_end = 1'b1; tick(); bus2.ld_end = 1'b0;
    checks++; if (bus2.ld_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got %b expected 1", bus2.ld_overflow); end
    bus2.ce = 1'b1; bus2.addr = 32'hC; #1;
    checks++; if (bus2.inst !== 32'h0D0E0F10) begin errors++; $display("[TB] FAIL ovf_mem3 got %h expected 0d0e0f10", bus2.inst); end
    bus2.addr = 32'h0; #1;
    checks++; if (bus2.inst !== 32'h01020304) begin errors++; $display("[TB] FAIL ovf_mem0 got %h expected 01020304", bus2.inst); end
    bus2.addr = 32'h10; #1;
    checks++; if (bus2.inst !== 32'h0) begin errors++; $display("[TB] FAIL ovf_out_of_range got %h expected 0", bus2.inst); end
  endtask

  task automatic test_reset_midload;
    start10();
    send10(8'h11); send10(8'h22); send10(8'h33); send10(8'h44); send10(8'h55); send10(8'h66);
    rst = 1'b0; tick(); rst = 1'b1;
    checks++; if (bus10.cpu_hold !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_hold got %b expected 0", bus10.cpu_hold); end
    checks++; if (bus10.ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ready got %b expected 0", bus10.ld_ready); end
    checks++; if (bus10.ld_words !== 11'd0) begin errors++; $display("[TB] FAIL rstmid_words got %0d expected 0", bus10.ld_words); end
    bus10.ce = 1'b1; bus10.addr = 32'h0; #1;
    checks++; if (bus10.inst !== 32'h11223344) begin errors++; $display("[TB] FAIL rstmid_mem0 got %h expected 11223344", bus10.inst); end
    bus10.addr = 32'h4; #1;
    checks++; if (bus10.inst !== 32'h34020020) begin errors++; $display("[TB] FAIL rstmid_mem1 got %h expected 34020020", bus10.inst); end
    start10();
    send10(8'hDE); send10(8'hAD); send10(8'hBE); send10(8'hEF);
    checks++; if (bus10.ld_words !== 11'd1) begin errors++; $display("[TB] FAIL rstmid_reload_words got %0d expected 1", bus10.ld_words); end
    bus10.addr = 32'h0; #1;
    checks++; if (bus10.inst !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rstmid_reload_mem0 got %h expected deadbeef", bus10.inst); end
    end10();
  endtask

  task automatic test_restart;
    start10();
    send10(8'h01); send10(8'h02); send10(8'h03); send10(8'h04); send10(8'h05);
    bus10.ld_start = 1'b1; bus10.ld_valid = 1'b1; bus10.ld_byte = 8'h99;
    tick();
    bus10.ld_start = 1'b0; bus10.ld_valid = 1'b0;
    checks++; if (bus10.ld_words !== 11'd0) begin errors++; $display("[TB] FAIL restart_words got %0d expected 0", bus10.ld_words); end
    checks++; if (bus10.cpu_hold !== 1'b1) begin errors++; $display("[TB] FAIL restart_hold got %b expected 1", bus10.cpu_hold); end
    send10(8'hA1); send10(8'hB2); send10(8'hC3); send10(8'hD4); send10(8'hE5);
    end10();
    checks++; if (bus10.ld_words !== 11'd2) begin errors++; $display("[TB] FAIL restart_final_words got %0d expected 2", bus10.ld_words); end
    bus10.ce = 1'b1; bus10.addr = 32'h0; #1;
    checks++; if (bus10.inst !== 32'hA1B2C3D4) begin errors++; $display("[TB] FAIL restart_mem0 got %h expected a1b2c3d4", bus10.inst); end
    bus10.addr = 32'h4; #1;
    checks++; if (bus10.inst !== 32'hE5000000) begin errors++; $display("[TB] FAIL restart_mem1 got %h expected e5000000", bus10.inst); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus10.ce = 1'b0; bus10.addr = 32'h0; bus10.ld_start = 1'b0; bus10.ld_valid = 1'b0;
    bus10.ld_byte = 8'h00; bus10.ld_end = 1'b0;
    bus2.ce = 1'b0; bus2.addr = 32'h0; bus2.ld_start = 1'b0; bus2.ld_valid = 1'b0;
    bus2.ld_byte = 8'h00; bus2.ld_end = 1'b0;
    test_reset();
    test_load();
    test_partial();
    test_fetch_guards();
    test_overflow();
    test_reset_midload();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
